// File: rtl/video_pkg.sv
// video_pkg: shared raster timing constants, beam position type and sync window helper.
package video_pkg;
  localparam int VCNT_W = 9;
  localparam int H_TOTAL = 384;
  localparam int H_ACTIVE = 256;
  localparam int H_SYNC_START = 296;
  localparam int H_SYNC_WIDTH = 32;
  localparam int V_TOTAL = 262;
  localparam int V_ACTIVE = 240;
  localparam int V_SYNC_START = 244;
  localparam int V_SYNC_WIDTH = 4;
  typedef struct packed {
    logic [VCNT_W-1:0] h;
    logic [VCNT_W-1:0] v;
  } raster_pos_t;
  // Half-open window; a window running past the total is clipped because the count never gets there.
  function automatic logic in_win(logic [10:0] x, logic [10:0] s, logic [10:0] w);
    return (x >= s) && (x < s + w);
  endfunction
endpackage

// File: rtl/mod_counter.sv
// mod_counter: enabled modulo-N counter with terminal-count ripple output.
module mod_counter
  import video_pkg::*;
#(
  parameter int WID = VCNT_W,
  parameter int MODULUS = 384
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  output logic [WID-1:0] q,
  output logic           tc
);
  localparam logic [WID-1:0] LAST = WID'(MODULUS - 1);
  assign tc = en & (q == LAST);
  always_ff @(posedge clk)
    q <= reset ? '0 : tc ? '0 : en ? q + WID'(1) : q;
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: chained h/v raster counters with co-registered blank/sync decode and line/frame strobes.
module video_timing_gen #(
  parameter int H_TOTAL = video_pkg::H_TOTAL,
  parameter int H_ACTIVE = video_pkg::H_ACTIVE,
  parameter int H_SYNC_START = video_pkg::H_SYNC_START,
  parameter int H_SYNC_WIDTH = video_pkg::H_SYNC_WIDTH,
  parameter int V_TOTAL = video_pkg::V_TOTAL,
  parameter int V_ACTIVE = video_pkg::V_ACTIVE,
  parameter int V_SYNC_START = video_pkg::V_SYNC_START,
  parameter int V_SYNC_WIDTH = video_pkg::V_SYNC_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pix_ce,
  output logic [video_pkg::VCNT_W-1:0] hcount,
  output logic [video_pkg::VCNT_W-1:0] vcount,
  output logic                         hblank,
  output logic                         vblank,
  output logic                         hsync_n,
  output logic                         vsync_n,
  output logic                         line_start,
  output logic                         frame_start
);
  import video_pkg::*;
  if (H_ACTIVE > H_TOTAL || V_ACTIVE > V_TOTAL) begin : g_bad_active
    $error("active region exceeds total");
  end
  if (H_TOTAL > 512 || V_TOTAL > 512 || H_TOTAL < 2 || V_TOTAL < 2) begin : g_bad_total
    $error("total out of range 2..512");
  end
  if (H_SYNC_WIDTH < 1 || V_SYNC_WIDTH < 1) begin : g_bad_sync
    $error("sync width must be at least 1");
  end
  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [10:0] VA = 11'(V_ACTIVE);
  localparam logic [10:0] HSS = 11'(H_SYNC_START);
  localparam logic [10:0] HSW = 11'(H_SYNC_WIDTH);
  localparam logic [10:0] VSS = 11'(V_SYNC_START);
  localparam logic [10:0] VSW = 11'(V_SYNC_WIDTH);
  logic h_tc, v_tc;
  raster_pos_t nxt;
  mod_counter #(.WID(VCNT_W), .MODULUS(H_TOTAL)) u_hcnt (
    .clk(clk), .reset(reset), .en(pix_ce), .q(hcount), .tc(h_tc)
  );
  mod_counter #(.WID(VCNT_W), .MODULUS(V_TOTAL)) u_vcnt (
    .clk(clk), .reset(reset), .en(h_tc), .q(vcount), .tc(v_tc)
  );
  // Decode from the next-state position so the flags land on the same edge as the counters.
  always_comb begin
    nxt.h = reset ? '0 : h_tc ? '0 : pix_ce ? hcount + VCNT_W'(1) : hcount;
    nxt.v = reset ? '0 : v_tc ? '0 : h_tc ? vcount + VCNT_W'(1) : vcount;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hblank  <= 1'b0;
      vblank  <= 1'b0;
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
    end else begin
      hblank  <= {2'b0, nxt.h} >= HA;
      vblank  <= {2'b0, nxt.v} >= VA;
      hsync_n <= !in_win({2'b0, nxt.h}, HSS, HSW);
      vsync_n <= !in_win({2'b0, nxt.v}, VSS, VSW);
    end
  end
  assign line_start = pix_ce & (hcount == '0);
  assign frame_start = line_start & (vcount == '0);
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: three geometries run in lockstep against a scoreboarded reference model.
module tb_video_timing_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_ce = 1'b0;
  always #5 clk = ~clk;
  logic [8:0] h0, v0, h1, v1, h2, v2;
  logic hb0, vb0, hs0, vs0, ls0, fs0;
  logic hb1, vb1, hs1, vs1, ls1, fs1;
  logic hb2, vb2, hs2, vs2, ls2, fs2;
  video_timing_gen u_def (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .hcount(h0), .vcount(v0), .hblank(hb0),
    .vblank(vb0), .hsync_n(hs0), .vsync_n(vs0), .line_start(ls0), .frame_start(fs0)
  );
  video_timing_gen #(.H_TOTAL(16), .H_ACTIVE(8), .H_SYNC_START(10), .H_SYNC_WIDTH(3)) u_mid (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .hcount(h1), .vcount(v1), .hblank(hb1),
    .vblank(vb1), .hsync_n(hs1), .vsync_n(vs1), .line_start(ls1), .frame_start(fs1)
  );
  video_timing_gen #(.H_TOTAL(8), .H_ACTIVE(4), .H_SYNC_START(6), .H_SYNC_WIDTH(4)) u_small (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .hcount(h2), .vcount(v2), .hblank(hb2),
    .vblank(vb2), .hsync_n(hs2), .vsync_n(vs2), .line_start(ls2), .frame_start(fs2)
  );
  logic [23:0] got [3];
  assign got[0] = {h0, v0, hb0, vb0, hs0, vs0, ls0, fs0};
  assign got[1] = {h1, v1, hb1, vb1, hs1, vs1, ls1, fs1};
  assign got[2] = {h2, v2, hb2, vb2, hs2, vs2, ls2, fs2};
  int ht[3] = '{384, 16, 8};
  int ha[3] = '{256, 8, 4};
  int hss[3] = '{296, 10, 6};
  int hsw[3] = '{32, 3, 4};
  int mh[3], mv[3];
  int hs_lo[3], ls_n[3], fs_n[3];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  typedef struct {
    int d;
    logic [23:0] e;
  } sb_t;
  sb_t sb[$];
  typedef struct {
    logic rst;
    logic [3:0] pat;
    int n;
    int eh;
    int ev;
  } vec_t;
  vec_t tbl[10];
  function automatic logic [23:0] expf(int d, logic ce);
    int h = mh[d];
    int v = mv[d];
    logic ls = ce && (h == 0);
    return {9'(h), 9'(v), h >= ha[d], v >= 240, !(h >= hss[d] && h < hss[d] + hsw[d]),
            !(v >= 244 && v < 248), ls, ls && (v == 0)};
  endfunction
  task automatic check(string name, logic [23:0] act, logic [23:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, req);
    end
  endtask
  task automatic step(logic r, logic ce);
    sb_t s;
    @(negedge clk);
    reset = r;
    pix_ce = ce;
    for (int d = 0; d < 3; d++) begin
      if (r) begin
        mh[d] = 0;
        mv[d] = 0;
      end else if (ce) begin
        if (mh[d] == ht[d] - 1) begin
          mh[d] = 0;
          mv[d] = (mv[d] == 261) ? 0 : mv[d] + 1;
        end else mh[d] = mh[d] + 1;
      end
      sb.push_back('{d, expf(d, ce)});
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      s = sb.pop_front();
      check($sformatf("model_dut%0d", s.d), got[s.d], s.e);
      hs_lo[s.d] += (got[s.d][3] == 1'b0) ? 1 : 0;
      ls_n[s.d] += got[s.d][1] ? 1 : 0;
      fs_n[s.d] += got[s.d][0] ? 1 : 0;
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0] = '{1'b1, 4'b1111, 3, 0, 0};
    tbl[1] = '{1'b0, 4'b1111, 383, 383, 0};
    tbl[2] = '{1'b0, 4'b1111, 1, 0, 1};
    tbl[3] = '{1'b0, 4'b1001, 400, 200, 1};
    tbl[4] = '{1'b0, 4'b0000, 10, 200, 1};
    tbl[5] = '{1'b1, 4'b1111, 1, 0, 0};
    tbl[6] = '{1'b0, 4'b1111, 4500, 276, 11};
    tbl[7] = '{1'b1, 4'b1111, 1, 0, 0};
    tbl[8] = '{1'b0, 4'b1111, 3931, 91, 10};
    tbl[9] = '{1'b1, 4'b1111, 1, 0, 0};
    for (int d = 0; d < 3; d++) begin
      mh[d] = 0;
      mv[d] = 0;
    end
    for (int i = 0; i < 10; i++) begin
      for (int d = 0; d < 3; d++) begin
        hs_lo[d] = 0;
        ls_n[d] = 0;
        fs_n[d] = 0;
      end
      for (int c = 0; c < tbl[i].n; c++) step(tbl[i].rst, tbl[i].pat[c % 4]);
      check($sformatf("vec%0d_pos", i), {h0, v0, 6'd0}, {9'(tbl[i].eh), 9'(tbl[i].ev), 6'd0});
      if (i == 1) begin
        check("hsync_low_width", 24'(hs_lo[0]), 24'd32);
        check("small_hsync_clip", 24'(hs_lo[2]), 24'd96);
        check("small_line_period", 24'(ls_n[2]), 24'd47);
      end
      if (i == 2) check("line_start_wrap", {ls_n[0][3:0], h0, v0, 2'd0}, {4'd1, 9'd0, 9'd1, 2'd0});
      if (i == 4) check("ce_low_no_strobe", 24'(ls_n[0] + ls_n[1] + ls_n[2]), 24'd0);
      if (i == 6) check("mid_frame_wrap", 24'(fs_n[1]), 24'd1);
      if (i == 8) check("mid_syncs_low", {h1, v1, hs1, vs1, 4'd0}, {9'd11, 9'd245, 2'b00, 4'd0});
      if (i == 9) check("mid_reset_vals", got[1], {9'd0, 9'd0, 6'b001111});
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
